// File: rtl/lcd_reader.sv
// Single-byte read from a 4-bit HD44780 bus: two E strobes with RW high,
// upper nibble first, returned to the requester on a one-cycle done pulse.
module lcd_reader #(
  parameter int T_AS = 4,
  parameter int T_EH = 46,
  parameter int T_EL = 54
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  input  logic [3:0] lcd_d_in,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_data
);

  // Handshake: req is taken on any edge where the reader is idle (busy=0,
  // which includes the done cycle); requests while busy are dropped, not
  // queued. done is a single-cycle pulse and rd_data holds until the next one.

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    E_HI1 = 3'd2,
    E_LO1 = 3'd3,
    E_HI2 = 3'd4,
    E_LO2 = 3'd5
  } state_t;

  localparam logic [7:0] AS_LOAD = 8'(T_AS - 1);
  localparam logic [7:0] EH_LOAD = 8'(T_EH - 1);
  localparam logic [7:0] EL_LOAD = 8'(T_EL - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       phase_end;
  logic       accept;
  logic       capture_hi;
  logic       capture_lo;
  logic       finish;

  logic [3:0] d_q;
  logic [3:0] nib_hi;
  logic [3:0] nib_lo;

  assign phase_end = (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Each phase loads N-1 on entry and leaves on the cycle the counter reads 0.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt - 8'd1;
    accept     = 1'b0;
    capture_hi = 1'b0;
    capture_lo = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = cnt;
        if (req) begin
          accept   = 1'b1;
          state_nx = SETUP;
          cnt_nx   = AS_LOAD;
        end
      end
      SETUP: begin
        if (phase_end) begin
          state_nx = E_HI1;
          cnt_nx   = EH_LOAD;
        end
      end
      E_HI1: begin
        if (phase_end) begin
          capture_hi = 1'b1;
          state_nx   = E_LO1;
          cnt_nx     = EL_LOAD;
        end
      end
      E_LO1: begin
        if (phase_end) begin
          state_nx = E_HI2;
          cnt_nx   = EH_LOAD;
        end
      end
      E_HI2: begin
        if (phase_end) begin
          capture_lo = 1'b1;
          state_nx   = E_LO2;
          cnt_nx     = EL_LOAD;
        end
      end
      E_LO2: begin
        if (phase_end) begin
          finish   = 1'b1;
          state_nx = IDLE;
          cnt_nx   = 8'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = 8'd0;
      end
    endcase
  end

  // Pad controls are registered from the next state so they change cleanly
  // on the same edge as the state; lcd_e can only rise after SETUP with RW=1.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q     <= 4'd0;
      nib_hi  <= 4'd0;
      nib_lo  <= 4'd0;
      lcd_e   <= 1'b0;
      lcd_rs  <= 1'b0;
      lcd_rw  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      d_q    <= lcd_d_in;
      done   <= finish;
      lcd_e  <= (state_nx == E_HI1) || (state_nx == E_HI2);
      lcd_rw <= (state_nx != IDLE);
      busy   <= (state_nx != IDLE);
      if (accept) begin
        lcd_rs <= req_rs;
      end else if (finish) begin
        lcd_rs <= 1'b0;
      end
      if (capture_hi) begin
        nib_hi <= d_q;
      end
      if (capture_lo) begin
        nib_lo <= d_q;
      end
      if (finish) begin
        rd_data <= {nib_hi, nib_lo};
      end
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Randomized bench for lcd_reader: LCD bus model, scoreboard of expected
// bytes/latencies, and a protocol monitor on the pad controls.
module tb_lcd_reader;

  localparam int T_AS  = 4;
  localparam int T_EH  = 46;
  localparam int T_EL  = 54;
  localparam int LAT   = 1 + T_AS + 2 * T_EH + 2 * T_EL;
  localparam int P_LAT = 1 + 1 + 2 * 3 + 2 * 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_d = 1'b1;
  logic       req = 1'b0;
  logic       req_rs = 1'b0;
  logic [3:0] lcd_d_in = 4'd0;
  logic       lcd_e, lcd_rs, lcd_rw, busy, done;
  logic [7:0] rd_data;

  logic       req_p = 1'b0;
  logic       req_rs_p = 1'b1;
  logic [3:0] lcd_d_in_p = 4'd0;
  logic       lcd_e_p, lcd_rs_p, lcd_rw_p, busy_p, done_p;
  logic [7:0] rd_data_p;

  int cyc = 0;
  int checks = 0;
  int passes = 0;
  int done_cnt = 0;
  int issued = 0;

  logic [7:0] exp_q[$];
  logic       exp_rs_q[$];
  logic [7:0] lcd_q[$];
  int         acc_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= rst;
  end

  lcd_reader #(.T_AS(T_AS), .T_EH(T_EH), .T_EL(T_EL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_rs(req_rs), .lcd_d_in(lcd_d_in),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .busy(busy),
    .done(done), .rd_data(rd_data)
  );

  lcd_reader #(.T_AS(1), .T_EH(3), .T_EL(1)) dut_p (
    .clk(clk), .rst(rst), .req(req_p), .req_rs(req_rs_p), .lcd_d_in(lcd_d_in_p),
    .lcd_e(lcd_e_p), .lcd_rs(lcd_rs_p), .lcd_rw(lcd_rw_p), .busy(busy_p),
    .done(done_p), .rd_data(rd_data_p)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // LCD model: presents the upper nibble on the first E pulse, lower on the second.
  logic       pe_lcd = 1'b0;
  logic       e_par = 1'b0;
  logic [7:0] cur = 8'h00;
  always @(negedge clk) begin
    if (rst_d) begin
      e_par = 1'b0;
    end else if (lcd_e === 1'b1 && !pe_lcd) begin
      if (!e_par) begin
        if (lcd_q.size() > 0) cur = lcd_q.pop_front();
        lcd_d_in = cur[7:4];
      end else begin
        lcd_d_in = cur[3:0];
      end
      e_par = ~e_par;
    end
    pe_lcd = (lcd_e === 1'b1);
  end

  logic pe_lcd_p = 1'b0;
  logic e_par_p = 1'b0;
  always @(negedge clk) begin
    if (rst_d) begin
      e_par_p = 1'b0;
    end else if (lcd_e_p === 1'b1 && !pe_lcd_p) begin
      lcd_d_in_p = e_par_p ? 4'hC : 4'h3;
      e_par_p = ~e_par_p;
    end
    pe_lcd_p = (lcd_e_p === 1'b1);
  end

  // Monitor: pops the scoreboard on every done and checks pad protocol.
  int   e_len = 0;
  int   rw_cnt = 0;
  logic rs_bad = 1'b0;
  logic pe_mon = 1'b0;
  always @(negedge clk) begin
    logic [7:0] e_byte;
    int a;
    if (rst_d) begin
      e_len = 0;
      rw_cnt = 0;
      rs_bad = 1'b0;
    end else begin
      if (lcd_e === 1'b1) begin
        if (!pe_mon) begin
          check("e_rise_rw", lcd_rw, 1);
          if (exp_rs_q.size() > 0) check("e_rise_rs", lcd_rs, exp_rs_q[0]);
        end
        e_len++;
      end else if (e_len > 0) begin
        check("e_width", e_len, T_EH);
        e_len = 0;
      end
      if (lcd_rw === 1'b1) begin
        rw_cnt++;
        if (exp_rs_q.size() > 0 && lcd_rs !== exp_rs_q[0]) rs_bad = 1'b1;
      end
      if (busy !== lcd_rw) rs_bad = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got done=1, expected no transaction (cycle %0d)", cyc);
        end else begin
          e_byte = exp_q.pop_front();
          void'(exp_rs_q.pop_front());
          a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
          check("rd_data", rd_data, e_byte);
          check("done_latency", cyc - a, LAT);
          check("rw_cycles", rw_cnt, LAT - 1);
          check("rs_rw_stable", rs_bad, 0);
        end
        rw_cnt = 0;
        rs_bad = 1'b0;
      end
    end
    pe_mon = (lcd_e === 1'b1);
  end

  task automatic push_exp(input logic rs, input logic [7:0] b);
    exp_q.push_back(b);
    exp_rs_q.push_back(rs);
    lcd_q.push_back(b);
    issued++;
  endtask

  task automatic start_read(input logic rs, input logic [7:0] b, output int a);
    @(negedge clk);
    req = 1'b1;
    req_rs = rs;
    push_exp(rs, b);
    a = cyc;
    acc_q.push_back(a);
    @(negedge clk);
    req = 1'b0;
    req_rs = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic pulse_ignored(input int at);
    while (cyc < at) @(negedge clk);
    req = 1'b1;
    req_rs = 1'($urandom_range(0, 1));
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    int a, n, n0, off;
    logic r1, r2;
    logic [7:0] b1, b2;

    // Reset held three cycles, then released with req low.
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("reset_outs", {lcd_e, lcd_rs, lcd_rw, busy, done, rd_data}, 0);
      check("reset_outs_p", {lcd_e_p, lcd_rs_p, lcd_rw_p, busy_p, done_p, rd_data_p}, 0);
      if (i == 2) rst = 1'b0;
    end

    // Busy-flag read then data read.
    start_read(1'b0, 8'h8A, a);
    wait_drain();
    start_read(1'b1, 8'h4D, a);
    wait_drain();

    // A request at cycle 50 of a read must not start another transaction.
    n0 = done_cnt;
    start_read(1'b1, 8'h5C, a);
    pulse_ignored(a + 50);
    wait_drain();
    repeat (LAT + 40) @(negedge clk);
    check("ignored_req", done_cnt, n0 + 1);

    // req held high through done: second read accepted on the done edge.
    r1 = 1'($urandom_range(0, 1));
    r2 = ~r1;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    @(negedge clk);
    req = 1'b1;
    req_rs = r1;
    push_exp(r1, b1);
    acc_q.push_back(cyc);
    push_exp(r2, b2);
    @(negedge clk);
    req_rs = r2;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("b2b_first_done_seen", done, 1);
    acc_q.push_back(cyc);
    @(negedge clk);
    req = 1'b0;
    n = 1;
    while (lcd_e !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("b2b_e_start", n, T_AS + 1);
    wait_drain();

    // Reset in the middle of E_HI2.
    n0 = done_cnt;
    start_read(1'b1, 8'hE7, a);
    while (cyc < a + 1 + T_AS + T_EH + T_EL + 10) @(negedge clk);
    check("mid_rst_in_e_hi2", lcd_e, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_rs_q.delete();
    lcd_q.delete();
    acc_q.delete();
    issued--;
    check("mid_rst_ctl", {lcd_e, lcd_rw, busy, done, lcd_rs}, 0);
    check("mid_rst_rd_data", rd_data, 0);
    repeat (LAT + 20) @(negedge clk);
    check("mid_rst_no_done", done_cnt, n0);

    // Short-timing instance.
    @(negedge clk);
    req_p = 1'b1;
    a = cyc;
    @(negedge clk);
    req_p = 1'b0;
    n = 0;
    while (done_p !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("param_latency", cyc - a, P_LAT);
    check("param_rd_data", rd_data_p, 8'h3C);

    // Randomized reads with idle gaps and occasional dropped requests.
    for (int i = 0; i < 14; i++) begin
      repeat ($urandom_range(0, 12)) @(negedge clk);
      start_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), a);
      if ($urandom_range(0, 2) == 0) begin
        off = $urandom_range(2, 200);
        pulse_ignored(a + off);
      end
      wait_drain();
    end

    repeat (20) @(negedge clk);
    check("total_reads", done_cnt, issued);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
